// File: rtl/cam_cfg_pkg.sv
// ============================================================================
// Module      : cam_cfg_pkg
// Description : Shared types and constants for the TCAM table loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_WRITE   = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_FLUSH = 1'b1;

    localparam int DEFAULT_DRAIN_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/cam_table_loader.sv
// ============================================================================
// Module      : cam_table_loader
// Description : Arbitrates program/flush commands against lookups and drives
//               the TCAM wrapper pins; keeps a shadow valid bitmap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_table_loader
    import cam_cfg_pkg::*;
#(
    parameter int ID_Width     = 4,
    parameter int AddressSize  = 4,
    parameter int Bits         = 8,
    parameter int Words        = 16,
    parameter int BankSize     = 1,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   cfg_op,
    input  logic [AddressSize-1:0] cfg_addr,
    input  logic [ID_Width-1:0]    cfg_key,
    input  logic [ID_Width-1:0]    cfg_key_mask,
    input  logic [ID_Width-1:0]    cfg_dst,
    input  logic                   cfg_vbit,
    input  logic                   lkp_req,
    output logic                   lkp_grant,
    output logic                   CS,
    output logic                   FLUSH,
    output logic                   VBE,
    output logic                   DCS,
    output logic                   WR,
    output logic                   VBI,
    output logic [Bits-1:0]        Data_In,
    output logic [Bits-1:0]        Mask_In,
    output logic [BankSize-1:0]    CBE,
    output logic [AddressSize-1:0] Addr_In,
    output logic [Words-1:0]       valid_map,
    output logic                   busy,
    output logic                   err
);

    localparam int c_CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_DRAIN_LOAD = c_CNT_W'(DRAIN_CYCLES - 1);

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_op;
    logic [AddressSize-1:0] r_addr;
    logic [ID_Width-1:0]    r_key;
    logic [ID_Width-1:0]    r_mask;
    logic [ID_Width-1:0]    r_dst;
    logic                   r_vbit;
    logic [Words-1:0]       r_valid_map;
    logic                   r_err;

    logic w_idle;
    logic w_write;
    logic w_flush;
    logic w_reject;

    assign w_reject = (cfg_op == OP_WRITE) && (32'(cfg_addr) >= Words);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= 1'b0;
            r_addr      <= '0;
            r_key       <= '0;
            r_mask      <= '0;
            r_dst       <= '0;
            r_vbit      <= 1'b0;
            r_valid_map <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        r_op   <= cfg_op;
                        r_addr <= cfg_addr;
                        r_key  <= cfg_key;
                        r_mask <= cfg_key_mask;
                        r_dst  <= cfg_dst;
                        r_vbit <= cfg_vbit;
                        if (w_reject) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_cnt   <= c_DRAIN_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state <= (r_op == OP_FLUSH) ? ST_FLUSH : ST_WRITE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WRITE: begin
                    for (int i = 0; i < Words; i++) begin
                        if (r_addr == AddressSize'(i)) begin
                            r_valid_map[i] <= r_vbit;
                        end
                    end
                    r_state <= ST_RECOVER;
                end
                ST_FLUSH: begin
                    r_valid_map <= '0;
                    r_state     <= ST_RECOVER;
                end
                ST_RECOVER: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Every pin is masked by rst so the wrapper sees idle pins the instant reset rises.
    assign w_idle  = !rst && (r_state == ST_IDLE);
    assign w_write = !rst && (r_state == ST_WRITE);
    assign w_flush = !rst && (r_state == ST_FLUSH);

    assign cfg_ready = w_idle;
    assign lkp_grant = w_idle && !cfg_valid;
    assign CS        = (lkp_req && lkp_grant) || w_write || w_flush;
    assign WR        = w_write;
    assign VBE       = w_write;
    assign DCS       = w_write;
    assign VBI       = w_write && r_vbit;
    assign FLUSH     = w_flush;
    assign Data_In   = w_write ? {r_key, r_dst} : '0;
    assign Mask_In   = w_write ? {r_mask, {ID_Width{1'b1}}} : '0;
    assign Addr_In   = w_write ? r_addr : '0;
    assign CBE       = '1;
    assign valid_map = r_valid_map;
    assign busy      = r_state != ST_IDLE;
    assign err       = r_err;

endmodule

`default_nettype wire
